// File: rtl/reg_dump_sequencer.sv
// Register-file dump controller: waits for processor halt, then sweeps the inr debug select and
// streams one {addr,data} beat per register on a valid/ready interface.
module reg_dump_sequencer #(
   parameter int unsigned RegAddrBits  = 3,
   parameter int unsigned DataWidth    = 16,
   parameter int unsigned TotalReg     = 8,
   parameter int unsigned SettleCycles = 1,
   parameter int unsigned HaltTimeout  = 64
) (
   input  logic                   CLK,
   input  logic                   RST,
   input  logic                   start,
   input  logic                   halted,
   output logic [RegAddrBits-1:0] inr,
   input  logic [DataWidth-1:0]   out_value,
   output logic                   dump_valid,
   input  logic                   dump_ready,
   output logic [RegAddrBits-1:0] dump_addr,
   output logic [DataWidth-1:0]   dump_data,
   output logic                   busy,
   output logic                   done,
   output logic                   err
);

   localparam int unsigned TimerBits  = (HaltTimeout > 0) ? $clog2(HaltTimeout + 1) : 1;
   localparam int unsigned SettleBits = (SettleCycles > 1) ? $clog2(SettleCycles) : 1;

   localparam logic [TimerBits-1:0]   TimerLast  = TimerBits'(HaltTimeout - 1);
   localparam logic [SettleBits-1:0]  SettleLast = SettleBits'(SettleCycles - 1);
   localparam logic [RegAddrBits-1:0] LastIdx    = RegAddrBits'(TotalReg - 1);

   typedef enum logic [2:0] {
      StIdle,
      StWaitHalt,
      StSettle,
      StSend,
      StDone
   } state_e;

   state_e                 state_q, state_d;
   logic [TimerBits-1:0]   timer_q, timer_d;
   logic [SettleBits-1:0]  settle_q, settle_d;
   logic [RegAddrBits-1:0] idx_q, idx_d;
   logic [RegAddrBits-1:0] dump_addr_q, dump_addr_d;
   logic [DataWidth-1:0]   dump_data_q, dump_data_d;
   logic                   dump_valid_q, dump_valid_d;
   logic                   busy_q, busy_d;
   logic                   done_q, done_d;
   logic                   err_q, err_d;

   always_comb begin
      state_d      = state_q;
      timer_d      = timer_q;
      settle_d     = settle_q;
      idx_d        = idx_q;
      dump_addr_d  = dump_addr_q;
      dump_data_d  = dump_data_q;
      dump_valid_d = dump_valid_q;
      err_d        = err_q;

      case (state_q)
         StIdle: begin
            if (start) begin
               state_d = StWaitHalt;
               timer_d = '0;
               err_d   = 1'b0;
            end
         end
         StWaitHalt: begin
            // halted takes priority over a timeout landing on the same edge
            if (halted) begin
               state_d  = StSettle;
               idx_d    = '0;
               settle_d = '0;
            end else if ((HaltTimeout != 32'd0) && (timer_q == TimerLast)) begin
               state_d = StDone;
               err_d   = 1'b1;
            end else if (timer_q != '1) begin
               timer_d = timer_q + 1'b1;
            end
         end
         StSettle: begin
            if (settle_q == SettleLast) begin
               dump_data_d  = out_value;
               dump_addr_d  = idx_q;
               dump_valid_d = 1'b1;
               state_d      = StSend;
            end else begin
               settle_d = settle_q + 1'b1;
            end
         end
         StSend: begin
            if (dump_ready) begin
               dump_valid_d = 1'b0;
               if (idx_q == LastIdx) begin
                  state_d = StDone;
               end else begin
                  idx_d    = idx_q + 1'b1;
                  settle_d = '0;
                  state_d  = StSettle;
               end
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase

      done_d = (state_d == StDone);
      busy_d = (state_d != StIdle);
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q      <= StIdle;
         timer_q      <= '0;
         settle_q     <= '0;
         idx_q        <= '0;
         dump_addr_q  <= '0;
         dump_data_q  <= '0;
         dump_valid_q <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         err_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         timer_q      <= timer_d;
         settle_q     <= settle_d;
         idx_q        <= idx_d;
         dump_addr_q  <= dump_addr_d;
         dump_data_q  <= dump_data_d;
         dump_valid_q <= dump_valid_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         err_q        <= err_d;
      end
   end

   assign inr        = idx_q;
   assign dump_valid = dump_valid_q;
   assign dump_addr  = dump_addr_q;
   assign dump_data  = dump_data_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign err        = err_q;

endmodule

// File: tb/tb_reg_dump_sequencer.sv
// Bench for reg_dump_sequencer: three instances (defaults, short halt timeout, three-cycle settle)
// each driven by a stub register file returning 16'hA000 + inr.
module tb_reg_dump_sequencer;

   logic CLK = 1'b0;
   logic RST = 1'b1;
   always #5 CLK = ~CLK;

   // default instance
   logic        start_a = 1'b0, halted_a = 1'b0, ready_a = 1'b0;
   logic [2:0]  inr_a, dump_addr_a;
   logic [15:0] out_a, dump_data_a;
   logic        dump_valid_a, busy_a, done_a, err_a;
   assign out_a = 16'hA000 + {13'd0, inr_a};

   // HaltTimeout = 16
   logic        start_b = 1'b0, halted_b = 1'b0, ready_b = 1'b0;
   logic [2:0]  inr_b, dump_addr_b;
   logic [15:0] out_b, dump_data_b;
   logic        dump_valid_b, busy_b, done_b, err_b;
   assign out_b = 16'hA000 + {13'd0, inr_b};

   // SettleCycles = 3
   logic        start_c = 1'b0, halted_c = 1'b0, ready_c = 1'b0;
   logic [2:0]  inr_c, dump_addr_c;
   logic [15:0] out_c, dump_data_c;
   logic        dump_valid_c, busy_c, done_c, err_c;
   assign out_c = 16'hA000 + {13'd0, inr_c};

   reg_dump_sequencer u_dut (
      .CLK(CLK), .RST(RST), .start(start_a), .halted(halted_a), .inr(inr_a),
      .out_value(out_a), .dump_valid(dump_valid_a), .dump_ready(ready_a),
      .dump_addr(dump_addr_a), .dump_data(dump_data_a), .busy(busy_a), .done(done_a),
      .err(err_a)
   );

   reg_dump_sequencer #(.HaltTimeout(16)) u_to (
      .CLK(CLK), .RST(RST), .start(start_b), .halted(halted_b), .inr(inr_b),
      .out_value(out_b), .dump_valid(dump_valid_b), .dump_ready(ready_b),
      .dump_addr(dump_addr_b), .dump_data(dump_data_b), .busy(busy_b), .done(done_b),
      .err(err_b)
   );

   reg_dump_sequencer #(.SettleCycles(3)) u_s3 (
      .CLK(CLK), .RST(RST), .start(start_c), .halted(halted_c), .inr(inr_c),
      .out_value(out_c), .dump_valid(dump_valid_c), .dump_ready(ready_c),
      .dump_addr(dump_addr_c), .dump_data(dump_data_c), .busy(busy_c), .done(done_c),
      .err(err_c)
   );

   typedef struct packed {
      logic [2:0]  addr;
      logic [15:0] data;
      logic [31:0] cyc;
   } beat_t;

   int          errors = 0;
   int          checks = 0;
   logic [18:0] exp_q[$];
   beat_t       obs_q[$];
   int          done_cycs[$];
   int          cyc = 0;
   int          stab_viol = 0;
   int          b2b_viol = 0;
   logic        prev_v = 1'b0, prev_hs = 1'b0, prev_rst = 1'b1;
   logic [2:0]  prev_addr = '0, prev_inr = '0;
   logic [15:0] prev_data = '0;

   // Observes the default instance between edges: handshakes, done pulses, hold and gap rules.
   always @(negedge CLK) begin
      logic hs;
      cyc++;
      hs = dump_valid_a && ready_a && !RST;
      if (!prev_rst && prev_v && !prev_hs) begin
         if (!(dump_valid_a && dump_addr_a == prev_addr && dump_data_a == prev_data &&
               inr_a == prev_inr)) stab_viol++;
      end
      if (dump_valid_a && prev_hs) b2b_viol++;
      if (hs) obs_q.push_back('{addr: dump_addr_a, data: dump_data_a, cyc: cyc});
      if (done_a) done_cycs.push_back(cyc);
      prev_v    = dump_valid_a;
      prev_hs   = hs;
      prev_rst  = RST;
      prev_addr = dump_addr_a;
      prev_data = dump_data_a;
      prev_inr  = inr_a;
   end

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic clear_a();
      exp_q.delete();
      obs_q.delete();
      done_cycs.delete();
      stab_viol = 0;
      b2b_viol  = 0;
   endtask

   task automatic start_dump_a();
      for (int i = 0; i < 8; i++) exp_q.push_back({3'(i), 16'hA000 + 16'(i)});
      start_a = 1'b1;
      tick();
      start_a = 1'b0;
   endtask

   task automatic wait_done_a(input string name);
      for (int c = 0; c < 200 && done_cycs.size() == 0; c++) tick();
      checks++;
      if (done_cycs.size() == 0) begin
         errors++;
         $display("FAIL %s_done_timeout: got no done pulse, expected one within 200 cycles", name);
      end
      tick();
      tick();
      tick();
   endtask

   task automatic test_reset();
      RST = 1'b1;
      tick();
      tick();
      checks++;
      if ({inr_a, dump_valid_a, dump_addr_a, dump_data_a} !== 23'd0) begin
         errors++;
         $display("FAIL reset_dump: got inr=%0d v=%0b addr=%0d data=%h, expected all 0",
                  inr_a, dump_valid_a, dump_addr_a, dump_data_a);
      end
      checks++;
      if ({busy_a, done_a, err_a, busy_b, busy_c} !== 5'b0) begin
         errors++;
         $display("FAIL reset_status: got busy=%0b done=%0b err=%0b busy_b=%0b busy_c=%0b, expected 0",
                  busy_a, done_a, err_a, busy_b, busy_c);
      end
      RST = 1'b0;
      tick();
      tick();
      checks++;
      if (busy_a !== 1'b0) begin
         errors++;
         $display("FAIL reset_idle: got busy=%0b, expected 0 without start", busy_a);
      end
   endtask

   task automatic test_basic();
      int gap_bad = 0;
      clear_a();
      halted_a = 1'b1;
      ready_a  = 1'b1;
      start_dump_a();
      wait_done_a("basic");
      checks++;
      if (obs_q.size() != 8) begin
         errors++;
         $display("FAIL basic_count: got %0d beats, expected 8", obs_q.size());
      end
      for (int i = 0; i < obs_q.size() && exp_q.size() > 0; i++) begin
         logic [18:0] e = exp_q.pop_front();
         checks++;
         if ({obs_q[i].addr, obs_q[i].data} !== e) begin
            errors++;
            $display("FAIL basic_beat_%0d: got addr=%0d data=%h, expected addr=%0d data=%h",
                     i, obs_q[i].addr, obs_q[i].data, e[18:16], e[15:0]);
         end
         if (i > 0 && obs_q[i].cyc - obs_q[i-1].cyc != 2) gap_bad++;
      end
      checks++;
      if (gap_bad != 0) begin
         errors++;
         $display("FAIL basic_spacing: got %0d beat gaps not equal to 2 cycles, expected 0", gap_bad);
      end
      checks++;
      if (done_cycs.size() != 1 || obs_q.size() == 0 ||
          done_cycs[0] != int'(obs_q[obs_q.size()-1].cyc) + 1) begin
         errors++;
         $display("FAIL basic_done: got %0d pulses (first at cyc %0d), expected 1 right after last beat",
                  done_cycs.size(), (done_cycs.size() > 0) ? done_cycs[0] : -1);
      end
      checks++;
      if ({busy_a, err_a, 1'(b2b_viol != 0)} !== 3'b000) begin
         errors++;
         $display("FAIL basic_end: got busy=%0b err=%0b b2b=%0d, expected 0 0 0",
                  busy_a, err_a, b2b_viol);
      end
   endtask

   task automatic test_backpressure();
      logic stalled = 1'b0;
      int   n3 = 0;
      clear_a();
      halted_a = 1'b1;
      ready_a  = 1'b1;
      start_dump_a();
      for (int c = 0; c < 200 && done_cycs.size() == 0; c++) begin
         tick();
         if (dump_valid_a && dump_addr_a == 3'd0) halted_a = 1'b0;
         if (!stalled && dump_valid_a && dump_addr_a == 3'd3) begin
            stalled = 1'b1;
            ready_a = 1'b0;
            for (int k = 0; k < 5; k++) begin
               checks++;
               if ({dump_valid_a, dump_addr_a, dump_data_a, inr_a} !== {1'b1, 3'd3, 16'hA003, 3'd3})
               begin
                  errors++;
                  $display("FAIL stall_hold_%0d: got v=%0b addr=%0d data=%h inr=%0d, expected 1 3 a003 3",
                           k, dump_valid_a, dump_addr_a, dump_data_a, inr_a);
               end
               tick();
            end
            ready_a = 1'b1;
         end
      end
      tick();
      tick();
      checks++;
      if (obs_q.size() != 8 || !stalled) begin
         errors++;
         $display("FAIL stall_count: got %0d beats (stall seen=%0b), expected 8 with stall",
                  obs_q.size(), stalled);
      end
      for (int i = 0; i < obs_q.size() && exp_q.size() > 0; i++) begin
         logic [18:0] e = exp_q.pop_front();
         if (obs_q[i].addr == 3'd3) n3++;
         checks++;
         if ({obs_q[i].addr, obs_q[i].data} !== e) begin
            errors++;
            $display("FAIL stall_beat_%0d: got addr=%0d data=%h, expected addr=%0d data=%h",
                     i, obs_q[i].addr, obs_q[i].data, e[18:16], e[15:0]);
         end
      end
      checks++;
      if (n3 != 1 || stab_viol != 0 || b2b_viol != 0) begin
         errors++;
         $display("FAIL stall_rules: got addr3 beats=%0d hold_viol=%0d b2b=%0d, expected 1 0 0",
                  n3, stab_viol, b2b_viol);
      end
   endtask

   task automatic test_timeout();
      int w = 0;
      int vseen = 0;
      halted_b = 1'b0;
      ready_b  = 1'b1;
      start_b  = 1'b1;
      tick();
      start_b  = 1'b0;
      while (!done_b && w < 100) begin
         if (dump_valid_b) vseen++;
         tick();
         w++;
      end
      checks++;
      if (w != 16) begin
         errors++;
         $display("FAIL timeout_latency: got done after %0d cycles, expected 16", w);
      end
      checks++;
      if ({done_b, err_b, busy_b} !== 3'b111 || vseen != 0) begin
         errors++;
         $display("FAIL timeout_flags: got done=%0b err=%0b busy=%0b beats=%0d, expected 1 1 1 0",
                  done_b, err_b, busy_b, vseen);
      end
      tick();
      checks++;
      if ({done_b, busy_b, err_b} !== 3'b001) begin
         errors++;
         $display("FAIL timeout_persist: got done=%0b busy=%0b err=%0b, expected 0 0 1",
                  done_b, busy_b, err_b);
      end
      start_b = 1'b1;
      tick();
      start_b = 1'b0;
      checks++;
      if ({busy_b, err_b} !== 2'b10) begin
         errors++;
         $display("FAIL timeout_clear: got busy=%0b err=%0b, expected 1 0", busy_b, err_b);
      end
   endtask

   task automatic test_start_ignored();
      clear_a();
      halted_a = 1'b1;
      ready_a  = 1'b1;
      start_dump_a();
      for (int c = 0; c < 200 && done_cycs.size() == 0; c++) begin
         tick();
         start_a = (busy_a && !done_a && (c % 3 == 0));
      end
      start_a = 1'b0;
      tick();
      tick();
      tick();
      checks++;
      if (obs_q.size() != 8 || done_cycs.size() != 1 || busy_a !== 1'b0) begin
         errors++;
         $display("FAIL ignore_start: got beats=%0d dones=%0d busy=%0b, expected 8 1 0",
                  obs_q.size(), done_cycs.size(), busy_a);
      end
      clear_a();
      start_dump_a();
      wait_done_a("fresh");
      checks++;
      if (obs_q.size() != 8) begin
         errors++;
         $display("FAIL fresh_count: got %0d beats, expected 8", obs_q.size());
      end
      for (int i = 0; i < obs_q.size() && exp_q.size() > 0; i++) begin
         logic [18:0] e = exp_q.pop_front();
         checks++;
         if ({obs_q[i].addr, obs_q[i].data} !== e) begin
            errors++;
            $display("FAIL fresh_beat_%0d: got addr=%0d data=%h, expected addr=%0d data=%h",
                     i, obs_q[i].addr, obs_q[i].data, e[18:16], e[15:0]);
         end
      end
   endtask

   task automatic test_reset_mid();
      logic found = 1'b0;
      int   vseen = 0;
      clear_a();
      halted_a = 1'b1;
      ready_a  = 1'b1;
      start_dump_a();
      for (int c = 0; c < 100 && !found; c++) begin
         tick();
         if (dump_valid_a && dump_addr_a == 3'd4) found = 1'b1;
      end
      checks++;
      if (!found) begin
         errors++;
         $display("FAIL rstmid_reach: got no addr-4 beat within 100 cycles, expected one");
      end
      ready_a = 1'b0;
      RST     = 1'b1;
      tick();
      RST     = 1'b0;
      checks++;
      if ({inr_a, dump_valid_a, dump_addr_a, dump_data_a, busy_a, done_a, err_a} !== 26'd0) begin
         errors++;
         $display("FAIL rstmid_outputs: got inr=%0d v=%0b addr=%0d data=%h busy=%0b done=%0b err=%0b, expected all 0",
                  inr_a, dump_valid_a, dump_addr_a, dump_data_a, busy_a, done_a, err_a);
      end
      ready_a = 1'b1;
      for (int c = 0; c < 20; c++) begin
         if (dump_valid_a || busy_a) vseen++;
         tick();
      end
      checks++;
      if (vseen != 0 || obs_q.size() != 4) begin
         errors++;
         $display("FAIL rstmid_quiet: got %0d active cycles, %0d beats total, expected 0 and 4",
                  vseen, obs_q.size());
      end
      exp_q.delete();
   endtask

   task automatic test_settle3();
      logic [18:0] exp_c[$];
      int          last_t = -1;
      int          t = 0;
      int          gap_bad = 0;
      int          nbeats = 0;
      for (int i = 0; i < 8; i++) exp_c.push_back({3'(i), 16'hA000 + 16'(i)});
      halted_c = 1'b0;
      ready_c  = 1'b1;
      start_c  = 1'b1;
      tick();
      start_c  = 1'b0;
      for (int i = 0; i < 9; i++) tick();
      halted_c = 1'b1;
      tick();
      checks++;
      if ({inr_c, dump_valid_c, busy_c} !== {3'd0, 1'b0, 1'b1}) begin
         errors++;
         $display("FAIL settle_entry: got inr=%0d v=%0b busy=%0b, expected 0 0 1",
                  inr_c, dump_valid_c, busy_c);
      end
      tick();
      tick();
      checks++;
      if (dump_valid_c !== 1'b0) begin
         errors++;
         $display("FAIL settle_early: got valid=%0b two edges after entry, expected 0", dump_valid_c);
      end
      tick();
      checks++;
      if ({dump_valid_c, dump_addr_c, dump_data_c} !== {1'b1, 3'd0, 16'hA000}) begin
         errors++;
         $display("FAIL settle_first: got v=%0b addr=%0d data=%h, expected 1 0 a000",
                  dump_valid_c, dump_addr_c, dump_data_c);
      end
      while (!done_c && t < 200) begin
         if (dump_valid_c && exp_c.size() > 0) begin
            logic [18:0] e = exp_c.pop_front();
            nbeats++;
            if (last_t >= 0 && t - last_t != 4) gap_bad++;
            last_t = t;
            checks++;
            if ({dump_addr_c, dump_data_c} !== e) begin
               errors++;
               $display("FAIL settle_beat_%0d: got addr=%0d data=%h, expected addr=%0d data=%h",
                        nbeats - 1, dump_addr_c, dump_data_c, e[18:16], e[15:0]);
            end
         end
         tick();
         t++;
      end
      checks++;
      if (nbeats != 8 || gap_bad != 0 || !done_c) begin
         errors++;
         $display("FAIL settle_sweep: got beats=%0d bad_gaps=%0d done=%0b, expected 8 0 1",
                  nbeats, gap_bad, done_c);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_backpressure();
      test_timeout();
      test_start_ignored();
      test_reset_mid();
      test_settle3();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got simulation still running at 200000, expected finish");
      $fatal(1, "watchdog expired");
   end

endmodule
